// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add WIDTH x WIDTH -> 2*WIDTH multiplier with start/busy/done handshake; optional signed mode via SEQ_MUL_SIGNED_EN
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [2*WIDTH-1:0] acc, acc_nxt, result;
  logic [WIDTH-1:0] mcand, a_mag, b_mag;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0] sum;
  logic neg, neg_in;
  // one iteration: conditional add into the upper half, then shift right with the carry
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : '0};
    acc_nxt = {sum, acc[WIDTH-1:1]};
    result = neg ? -acc_nxt : acc_nxt;
  end
`ifdef SEQ_MUL_SIGNED_EN
  // signed operands are reduced to WIDTH-bit magnitudes; -2^(W-1) maps to 2^(W-1)
  always_comb begin
    neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  end
`else
  // unsigned only: operands pass straight through
  always_comb begin
    neg_in = 1'b0;
    a_mag = a;
    b_mag = b;
  end
`endif
  // control FSM and datapath registers; a start in DONE chains straight into RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      count <= '0;
      neg <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
    end else if (start && state != RUN) begin
      state <= RUN;
      mcand <= a_mag;
      acc <= {{WIDTH{1'b0}}, b_mag};
      count <= CNT_W'(WIDTH);
      neg <= neg_in;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      count <= count - 1'b1;
      if (count == CNT_W'(1)) begin
        state <= DONE;
        product <= result;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier at WIDTH=4
module tb_seq_multiplier;
  localparam int W = 4;
  typedef struct {logic [2*W-1:0] p; int c;} exp_t;
  logic clk = 0, rst = 1, start = 0, sgn = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [2*W-1:0] product;
  int cyc = 0, applied = 0, miscompares = 0, dones = 0;
  exp_t q[$];
  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SEQ_MUL_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy), .done(done), .product(product)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int req);
    applied++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask
  // monitor: every done pops one expectation and checks value and latency
  always @(negedge clk) begin
    if (!rst && done) begin
      dones++;
      if (q.size() == 0) check("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("product", int'(product), int'(e.p));
        check("latency", cyc, e.c);
      end
    end
  end
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic [2*W-1:0] p);
    exp_t e;
    a = x; b = y; sgn = s; start = 1;
    @(posedge clk); #1;
    start = 0; a = ~x; b = ~y;
    e.p = p; e.c = cyc + W;
    q.push_back(e);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) check("done_timeout", 0, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    rst = 0;
    @(negedge clk);
    issue(4'd10, 4'd15, 0, 8'd150);
    check("busy_e0", busy, 1);
    repeat (3) begin
      @(negedge clk);
      check("busy_run", busy, 1);
    end
    wait_done();
    check("busy_at_done", busy, 0);
    @(negedge clk);
    issue(4'd3, 4'd5, 0, 8'd15);
    wait_done();
    issue(4'd15, 4'd15, 0, 8'd225);
    wait_done();
    issue(4'd0, 4'd9, 0, 8'd0);
    wait_done();
    repeat (5) @(negedge clk);
    check("hold_zero", product, 0);
    issue(4'd9, 4'd0, 0, 8'd0);
    wait_done();
    @(negedge clk);
    issue(4'd6, 4'd7, 0, 8'd42);
    repeat (2) @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_ignored_start", busy, 1);
    check("product_stable_run", product, 0);
    wait_done();
    repeat (8) @(negedge clk);
    check("done_count", dones, 6);
    check("product_held", product, 42);
    issue(4'd13, 4'd11, 0, 8'd143);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_done", done, 0);
    q.delete();
    #1 rst = 0;
    @(negedge clk);
    issue(4'd12, 4'd12, 0, 8'd144);
    wait_done();
    repeat (4) @(negedge clk);
    check("done_count_after_abort", dones, 7);
`ifdef SEQ_MUL_SIGNED_EN
    issue(4'hD, 4'd5, 1, 8'hF1);
    wait_done();
    issue(4'h8, 4'h8, 1, 8'h40);
    wait_done();
    issue(4'h8, 4'd7, 1, 8'hC8);
    wait_done();
    issue(4'hD, 4'd5, 0, 8'd65);
    wait_done();
    repeat (2) @(negedge clk);
`endif
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
